// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and oversampling constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  // 16 clken strobes per bit; the start bit is confirmed at its centre (7).
  localparam int         OVERSAMPLE  = 16;
  localparam logic [3:0] MID_SAMPLE  = 4'd7;
  // Once re-aligned to mid start bit, sample 15 lands on the next bit's centre.
  localparam logic [3:0] LAST_SAMPLE = 4'(OVERSAMPLE - 1);

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs, with a selectable reset value.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_50m,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two back-to-back flops; the first may go metastable, the second resolves it.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, mid-bit sampling, sticky ready/overrun, framing-error detect.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk_50m,
  input  logic                 rst_n,
  input  logic                 clken,
  input  logic                 rx,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] data,
  output logic                 rdy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int               IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state, state_n;
  logic [3:0]           sample, sample_n;
  logic [IDX_W-1:0]     bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 frame_ok;
  logic                 frame_bad;

  // Line idles high, so the synchroniser resets to 1 to avoid a false start bit.
  sync_2ff #(
    .WIDTH  (1),
    .RST_VAL(1'b1)
  ) u_rx_sync (
    .clk_50m(clk_50m),
    .rst_n  (rst_n),
    .d      (rx),
    .q      (rx_s)
  );

  // FSM, counters and shift register state.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sample  <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      sample  <= sample_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
    end
  end

  // Next-state logic; everything advances only on clken strobes.
  always_comb begin
    state_n   = state;
    sample_n  = sample;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    if (clken) begin
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state_n  = START;
            sample_n = '0;
          end
        end
        START: begin
          if (rx_s) begin
            // Line went back high before mid start bit: treat as a glitch.
            state_n = IDLE;
          end else if (sample == MID_SAMPLE) begin
            state_n   = DATA;
            sample_n  = '0;
            bit_idx_n = '0;
          end else begin
            sample_n = sample + 4'd1;
          end
        end
        DATA: begin
          sample_n = sample + 4'd1;
          if (sample == LAST_SAMPLE) begin
            shreg_n[bit_idx] = rx_s;
            if (bit_idx == LAST_IDX) begin
              state_n  = STOP;
              sample_n = '0;
            end else begin
              bit_idx_n = bit_idx + 1'b1;
            end
          end
        end
        STOP: begin
          sample_n = sample + 4'd1;
          if (sample == LAST_SAMPLE) begin
            sample_n = '0;
            if (rx_s) begin
              frame_ok = 1'b1;
              state_n  = IDLE;
            end else begin
              frame_bad = 1'b1;
              state_n   = BREAK;
            end
          end
        end
        BREAK: begin
          // Hold here while the line stays low so a break yields a single error.
          if (rx_s) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Host-visible flags; a completing frame takes priority over a coincident clear.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      data      <= '0;
      rdy       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (frame_ok) begin
        data      <= shreg;
        rdy       <= 1'b1;
        frame_err <= 1'b0;
        overrun   <= rdy_clr ? 1'b0 : (overrun | rdy);
      end else begin
        if (rdy_clr) begin
          rdy     <= 1'b0;
          overrun <= 1'b0;
        end
        if (frame_bad) frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: serial frames in, expected flag/data tuples checked by a monitor.
module tb_uart_rx;
  import uart_pkg::*;

  logic       clk_50m = 1'b0;
  logic       rst_n   = 1'b0;
  logic       clken   = 1'b0;
  logic       rx      = 1'b1;
  logic       rdy_clr = 1'b0;
  logic [7:0] data;
  logic       rdy, frame_err, overrun;

  int checks = 0;
  int errors = 0;
  int strobes = 0;
  int cnt = 0;
  int div = 28;

  typedef struct packed {
    logic [7:0] d;
    logic       r;
    logic       f;
    logic       o;
  } exp_t;
  exp_t q[$];

  // Reference state of the host-visible registers.
  logic [7:0] m_data = 8'h00;
  logic       m_rdy  = 1'b0;
  logic       m_ferr = 1'b0;
  logic       m_ovr  = 1'b0;

  uart_rx #(.DATA_BITS(8)) dut (
    .clk_50m  (clk_50m),
    .rst_n    (rst_n),
    .clken    (clken),
    .rx       (rx),
    .rdy_clr  (rdy_clr),
    .data     (data),
    .rdy      (rdy),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  initial forever #10 clk_50m = ~clk_50m;

  // Baud strobe: one clken cycle every div clocks, changed just after the edge.
  initial forever begin
    @(posedge clk_50m);
    #2;
    if (cnt >= div - 1) begin
      cnt = 0;
      clken = 1'b1;
      strobes++;
    end else begin
      cnt++;
      clken = 1'b0;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_50m);
  endtask

  // Update the reference registers for one frame and queue the expected outcome.
  task automatic push(input logic [7:0] b, input logic stop_ok, input logic coinc);
    exp_t e;
    if (stop_ok) begin
      m_ovr  = coinc ? 1'b0 : (m_ovr | m_rdy);
      m_rdy  = 1'b1;
      m_ferr = 1'b0;
      m_data = b;
    end else begin
      m_ferr = 1'b1;
    end
    e.d = m_data; e.r = m_rdy; e.f = m_ferr; e.o = m_ovr;
    q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b, input logic stop_v, input int bitlen);
    rx = 1'b0;
    cyc(bitlen);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cyc(bitlen);
    end
    rx = stop_v;
    cyc(bitlen);
  endtask

  task automatic frame(input logic [7:0] b, input logic stop_v, input int bitlen, input logic coinc);
    push(b, stop_v, coinc);
    send(b, stop_v, bitlen);
  endtask

  task automatic clr();
    rdy_clr = 1'b1;
    cyc(1);
    rdy_clr = 1'b0;
    m_rdy = 1'b0;
    m_ovr = 1'b0;
    check("clr_rdy", int'(rdy), 0);
    check("clr_ovr", int'(overrun), 0);
  endtask

  // Leaves us 4 clocks after a strobe edge so the next strobe sees the start bit.
  task automatic align(output int s);
    int n = 0;
    do begin
      cyc(1);
      n++;
    end while (!clken && n < 200);
    s = strobes;
    cyc(4);
  endtask

  // Monitor: any visible completion or error event is matched against the queue.
  initial begin
    logic [7:0] pd;
    logic       pr, pf, po;
    exp_t       e;
    pd = '0; pr = 1'b0; pf = 1'b0; po = 1'b0;
    forever begin
      @(negedge clk_50m);
      if (rst_n && ((rdy && !pr) || (overrun && !po) || (frame_err && !pf) || (rdy && data != pd))) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: data=%h rdy=%b ferr=%b ovr=%b", data, rdy, frame_err, overrun);
        end else begin
          e = q.pop_front();
          if ({data, rdy, frame_err, overrun} !== e) begin
            errors++;
            $display("FAIL frame: got data=%h rdy=%b ferr=%b ovr=%b expected data=%h rdy=%b ferr=%b ovr=%b",
                     data, rdy, frame_err, overrun, e.d, e.r, e.f, e.o);
          end
        end
      end
      pd = data; pr = rdy; pf = frame_err; po = overrun;
    end
  end

  initial begin
    int s0, tgt, bl, gap, n;
    logic [7:0] b;
    logic bad, prev_bad;
    int bitc;
    bitc = 16 * div;

    // Reset state.
    cyc(5);
    check("rst_data", int'(data), 0);
    check("rst_rdy", int'(rdy), 0);
    check("rst_ferr", int'(frame_err), 0);
    check("rst_ovr", int'(overrun), 0);
    rst_n = 1'b1;
    cyc(2 * bitc);

    // Good byte, then clear.
    align(s0);
    frame(8'hA5, 1'b1, bitc, 1'b0);
    cyc(bitc);
    clr();

    // Back-to-back frames without a clear: overrun.
    frame(8'h3C, 1'b1, bitc, 1'b0);
    frame(8'hC3, 1'b1, bitc, 1'b0);
    cyc(bitc);
    clr();

    // Start-bit glitch of 4 strobes, then a normal frame.
    rx = 1'b0;
    cyc(4 * div);
    rx = 1'b1;
    cyc(2 * bitc);
    check("glitch_rdy", int'(rdy), 0);
    frame(8'h55, 1'b1, bitc, 1'b0);
    cyc(bitc);

    // Clear landing on the completion strobe (detection + 152) with rdy already 1.
    align(s0);
    tgt = s0 + 1 + 152;
    fork
      frame(8'h81, 1'b1, bitc, 1'b1);
      begin
        n = 0;
        while (!(clken && strobes == tgt) && n < 20000) begin
          cyc(1);
          n++;
        end
        if (n >= 20000) check("collide_timeout", n, 0);
        rdy_clr = 1'b1;
        cyc(1);
        rdy_clr = 1'b0;
      end
    join
    cyc(bitc);
    clr();

    // Framing error followed by a 3-frame break.
    frame(8'hFF, 1'b0, bitc, 1'b0);
    cyc(30 * bitc);
    rx = 1'b1;
    cyc(2 * bitc);
    check("brk_ferr", int'(frame_err), 1);
    check("brk_rdy", int'(rdy), 0);
    check("brk_data", int'(data), int'(m_data));
    frame(8'h12, 1'b1, bitc, 1'b0);
    cyc(bitc);

    // Reset during bit 4, then a clean frame.
    b = 8'hAB;
    rx = 1'b0;
    cyc(bitc);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      cyc(bitc);
    end
    rx = b[4];
    cyc(bitc / 2);
    rst_n = 1'b0;
    rx = 1'b1;
    #1;
    check("mid_rst_data", int'(data), 0);
    check("mid_rst_rdy", int'(rdy), 0);
    check("mid_rst_ferr", int'(frame_err), 0);
    check("mid_rst_ovr", int'(overrun), 0);
    check("mid_rst_state", int'(dut.state), int'(IDLE));
    m_data = '0; m_rdy = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(2 * bitc);
    frame(8'h7E, 1'b1, bitc, 1'b0);
    cyc(bitc);

    // Randomized frames on a faster strobe with slight baud mismatch.
    div = 4;
    cyc(200);
    prev_bad = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (m_ovr || $urandom_range(1) == 1) clr();
      bad = !m_ferr && ($urandom_range(4) == 0);
      bl  = $urandom_range(65, 63);
      gap = prev_bad ? 80 + $urandom_range(40) : $urandom_range(80);
      b   = 8'($urandom);
      cyc(gap);
      frame(b, !bad, bl, 1'b0);
      rx = 1'b1;
      prev_bad = bad;
    end
    cyc(200);

    // Drain: every queued expectation must have been observed.
    n = 0;
    while (q.size() != 0 && n < 2000) begin
      cyc(1);
      n++;
    end
    check("drain", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
